// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, fetch buffer entry layout and
// front-end constants used by the instruction fetch unit.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned MAX_OUTSTANDING  = 4;

  typedef enum logic [0:0] {
    ST_START = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, data} with push, pop and flush.
// The head entry is presented directly from storage.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head_pc,
  output logic [31:0] head_data,
  output logic [2:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [2:0]      count_r;
  logic            do_push_s;
  logic            do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_pop_s  = pop && (count_r != 3'd0);
  assign do_push_s = push && ((count_r < 3'(DEPTH)) || do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= 3'd0;
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= 3'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= fetch_entry_t'{pc: push_pc, data: push_data};
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + {2'b00, do_push_s} - {2'b00, do_pop_s};
    end
  end

  assign head_pc   = mem_r[rd_ptr_r].pc;
  assign head_data = mem_r[rd_ptr_r].data;
  assign count     = count_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses for decode, and discards responses to fetches older than a redirect.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready
);

  localparam logic [31:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  fetch_pc_r, fetch_pc_nxt_s;
  logic [2:0]   live_out_r, live_out_nxt_s;
  logic [2:0]   total_out_r, total_out_nxt_s;
  logic [2:0]   drop_cnt_r, drop_cnt_nxt_s;
  logic [2:0]   inflight_s;
  logic [2:0]   fifo_count_s;
  logic         req_fire_s, inst_fire_s, rsp_live_s, rsp_drop_s, push_s, pop_s;

  // Credits: live fetches plus buffered entries never exceed the buffer size
  assign imem_req_valid = (state_r == ST_RUN)
                       && (({1'b0, live_out_r} + {1'b0, fifo_count_s}) < 4'(DEPTH))
                       && (total_out_r < 3'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign inst_valid     = (fifo_count_s != 3'd0);
  assign inst_fire_s    = inst_valid && inst_ready;
  // Responses return in order, so stale ones always precede live ones
  assign rsp_drop_s     = imem_rsp_valid && (drop_cnt_r != 3'd0);
  assign rsp_live_s     = imem_rsp_valid && (drop_cnt_r == 3'd0) && (live_out_r != 3'd0);
  assign push_s         = rsp_live_s && !redirect_valid;
  assign pop_s          = inst_fire_s && !redirect_valid;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_pc   (fetch_pc_of_rsp(fetch_pc_r, live_out_r, fifo_count_s)),
    .push_data (imem_rsp_data),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head_pc   (inst_pc),
    .head_data (inst_data),
    .count     (fifo_count_s)
  );

  // Live fetches occupy the addresses just below fetch_pc; the oldest is the one returning
  function automatic logic [31:0] fetch_pc_of_rsp(input logic [31:0] pc,
                                                  input logic [2:0]  live,
                                                  input logic [2:0]  unused_cnt);
    logic [2:0] ignore_s;
    ignore_s = unused_cnt;
    return pc - {27'd0, live, 2'b00} + {29'd0, ignore_s & 3'd0};
  endfunction

  // Next-state, fetch address and in-flight bookkeeping
  always_comb begin
    state_nxt_s     = state_r;
    fetch_pc_nxt_s  = fetch_pc_r;
    live_out_nxt_s  = live_out_r;
    drop_cnt_nxt_s  = drop_cnt_r;
    inflight_s      = total_out_r + {2'b00, req_fire_s} - {2'b00, (rsp_live_s || rsp_drop_s)};
    total_out_nxt_s = inflight_s;
    case (state_r)
      ST_START: state_nxt_s = ST_RUN;
      ST_RUN:   state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_START;
    endcase
    if (redirect_valid) begin
      fetch_pc_nxt_s = align_word(redirect_pc);
      live_out_nxt_s = 3'd0;
      drop_cnt_nxt_s = inflight_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      live_out_nxt_s = live_out_r + {2'b00, req_fire_s} - {2'b00, rsp_live_s};
      drop_cnt_nxt_s = drop_cnt_r - {2'b00, rsp_drop_s};
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_START;
      fetch_pc_r  <= RESET_PC_ALIGNED;
      live_out_r  <= 3'd0;
      total_out_r <= 3'd0;
      drop_cnt_r  <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      fetch_pc_r  <= fetch_pc_nxt_s;
      live_out_r  <= live_out_nxt_s;
      total_out_r <= total_out_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
    end
  end

endmodule
